// File: rtl/histogram_equalizer_pkg.sv
// Shared constants for the histogram equalizer: FSM encoding, RAM timing and
// the decoder command code that triggers equalization.
package histogram_equalizer_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LUT_READ  = 3'd1;
  localparam logic [2:0] ST_LUT_LATCH = 3'd2;
  localparam logic [2:0] ST_LUT_DIV   = 3'd3;
  localparam logic [2:0] ST_PIX_READ  = 3'd4;
  localparam logic [2:0] ST_PIX_WRITE = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  localparam int RAM_READ_LATENCY = 1;
  localparam logic [15:0] CMD_HISTOGRAM_EQUALIZATION = 16'hA050;

  // Numerator must hold (c - CDF_min) * (L-1) + D/2 without overflow.
  function automatic int num_width(input int cdf_width, input int pixel_width);
    return cdf_width + pixel_width;
  endfunction

endpackage

// File: rtl/histogram_equalizer_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The first bit is
// resolved on the start edge so done pulses exactly NUM_W cycles after start.
module seq_divider #(
  parameter int NUM_W = 25,
  parameter int DIV_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DIV_W-1:0] divisor,
  output logic [NUM_W-1:0] quotient,
  output logic             done
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [DIV_W-1:0] rem;
  logic [NUM_W-1:0] work;
  logic [NUM_W-1:0] quo;
  logic [CNT_W-1:0] cnt;

  logic [DIV_W-1:0] src_rem;
  logic [NUM_W-1:0] src_work;
  logic [NUM_W-1:0] src_quo;
  logic [DIV_W:0]   trial;
  logic             fits;
  logic [DIV_W-1:0] next_rem;

  always_comb begin
    src_rem  = start ? '0 : rem;
    src_work = start ? numerator : work;
    src_quo  = start ? '0 : quo;
    trial    = {src_rem, src_work[NUM_W-1]};
    fits     = trial >= {1'b0, divisor};
    next_rem = fits ? DIV_W'(trial - {1'b0, divisor}) : trial[DIV_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      work <= '0;
      quo  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || cnt != '0) begin
        rem  <= next_rem;
        work <= src_work << 1;
        quo  <= {src_quo[NUM_W-2:0], fits};
        cnt  <= start ? CNT_W'(NUM_W - 1) : cnt - CNT_W'(1);
        if (!start && cnt == CNT_W'(1)) done <= 1'b1;
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/histogram_equalizer.sv
// Builds a level-mapping LUT from the CDF in histogram RAM, then rewrites
// every pixel of image RAM in place with its equalized level.
module histogram_equalizer
  import histogram_equalizer_pkg::*;
#(
  parameter int IMAGE_WIDTH                 = 320,
  parameter int IMAGE_HEIGHT                = 240,
  parameter int PIXEL_WIDTH                 = 8,
  parameter int IMAGE_RAM_ADDRESS_WIDTH     = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
  parameter int HISTOGRAM_RAM_ADDRESS_WIDTH = PIXEL_WIDTH,
  parameter int HISTOGRAM_RAM_DATA_WIDTH    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    CDF_min,
  output logic [HISTOGRAM_RAM_ADDRESS_WIDTH-1:0] histogram_RAM_address,
  input  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    histogram_RAM_rdata,
  output logic                                   histogram_RAM_CE,
  output logic [IMAGE_RAM_ADDRESS_WIDTH-1:0]     image_RAM_address,
  input  logic [PIXEL_WIDTH-1:0]                 image_RAM_rdata,
  output logic [PIXEL_WIDTH-1:0]                 image_RAM_wdata,
  output logic                                   image_RAM_CE,
  output logic                                   image_RAM_WE,
  output logic                                   busy,
  output logic                                   done,
  output logic [2:0]                             fsm_state
);

  localparam int N     = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int L     = 1 << PIXEL_WIDTH;
  localparam int HD    = HISTOGRAM_RAM_DATA_WIDTH;
  localparam int NUM_W = num_width(HD, PIXEL_WIDTH);
  localparam logic [NUM_W-1:0] LEVEL_MAX = NUM_W'(L - 1);
  localparam logic [HD-1:0] N_W = HD'(N);
  localparam logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] LAST_PIX = IMAGE_RAM_ADDRESS_WIDTH'(N - 1);
  localparam logic [HISTOGRAM_RAM_ADDRESS_WIDTH-1:0] LAST_LEVEL = '1;

  logic [2:0]                             state;
  logic [HISTOGRAM_RAM_ADDRESS_WIDTH-1:0] k;
  logic [IMAGE_RAM_ADDRESS_WIDTH-1:0]     a;
  logic [HD-1:0]                          cdf_min_q;
  logic [HD-1:0]                          span;
  logic [HD-1:0]                          cdf_off;
  logic [PIXEL_WIDTH-1:0]                 lut [L];

  logic                   div_start;
  logic                   div_done;
  logic [NUM_W-1:0]       numer;
  logic [NUM_W-1:0]       quotient;
  logic                   lut_we;
  logic [PIXEL_WIDTH-1:0] lut_wdata;
  logic                   level_done;

  assign span    = N_W - cdf_min_q;
  assign cdf_off = histogram_RAM_rdata - cdf_min_q;

  always_comb begin
    div_start  = 1'b0;
    lut_we     = 1'b0;
    lut_wdata  = '0;
    level_done = 1'b0;
    numer      = {{PIXEL_WIDTH{1'b0}}, cdf_off} * LEVEL_MAX
               + {{PIXEL_WIDTH{1'b0}}, span >> 1};
    case (state)
      ST_LUT_LATCH: begin
        if (span == '0) begin
          lut_we     = 1'b1;
          lut_wdata  = PIXEL_WIDTH'(k);
          level_done = 1'b1;
        end else if (histogram_RAM_rdata < cdf_min_q) begin
          lut_we     = 1'b1;
          level_done = 1'b1;
        end else begin
          div_start = 1'b1;
        end
      end
      ST_LUT_DIV: begin
        if (div_done) begin
          lut_we     = 1'b1;
          lut_wdata  = (quotient > LEVEL_MAX) ? '1 : quotient[PIXEL_WIDTH-1:0];
          level_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  seq_divider #(.NUM_W(NUM_W), .DIV_W(HD)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .numerator (numer),
    .divisor   (span),
    .quotient  (quotient),
    .done      (div_done)
  );

  always_ff @(posedge clk) begin
    if (lut_we) lut[k] <= lut_wdata;
  end

  // start/done handshake: start is a one-cycle request honoured only in IDLE;
  // busy covers the whole operation and done is a single-cycle pulse after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      k         <= '0;
      a         <= '0;
      cdf_min_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cdf_min_q <= CDF_min;
            k         <= '0;
            state     <= ST_LUT_READ;
          end
        end
        ST_LUT_READ:  state <= ST_LUT_LATCH;
        ST_LUT_LATCH: if (div_start) state <= ST_LUT_DIV;
        ST_LUT_DIV:   ;
        ST_PIX_READ:  state <= ST_PIX_WRITE;
        ST_PIX_WRITE: begin
          if (a == LAST_PIX) state <= ST_DONE;
          else begin
            a     <= a + 1'b1;
            state <= ST_PIX_READ;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A finished level overrides the per-state transition above.
      if (level_done) begin
        if (k == LAST_LEVEL) begin
          a     <= '0;
          state <= ST_PIX_READ;
        end else begin
          k     <= k + 1'b1;
          state <= ST_LUT_READ;
        end
      end
    end
  end

  always_comb begin
    histogram_RAM_CE      = (state == ST_LUT_READ);
    histogram_RAM_address = histogram_RAM_CE ? k : '0;
    image_RAM_CE          = (state == ST_PIX_READ) || (state == ST_PIX_WRITE);
    image_RAM_WE          = (state == ST_PIX_WRITE);
    image_RAM_address     = image_RAM_CE ? a : '0;
    image_RAM_wdata       = image_RAM_WE ? lut[image_RAM_rdata] : '0;
    busy                  = (state != ST_IDLE) && (state != ST_DONE);
    done                  = (state == ST_DONE);
    fsm_state             = state;
  end

endmodule

// File: tb/tb_histogram_equalizer.sv
// Bench for histogram_equalizer on an 8x8 image with 1-cycle RAM models,
// checked against an arithmetic equalization model.
module tb_histogram_equalizer;
  import histogram_equalizer_pkg::*;

  localparam int W = 8, H = 8, N = 64, PW = 8, L = 256;
  localparam int IAW = 6, HAW = 8, HD = 7, NUM_W = HD + PW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cdf_generated = 1'b0;
  logic [15:0] command = '0;
  logic start;
  logic [HD-1:0]  cdf_min_in = '0;
  logic [HAW-1:0] histogram_RAM_address;
  logic [HD-1:0]  histogram_RAM_rdata = '0;
  logic           histogram_RAM_CE;
  logic [IAW-1:0] image_RAM_address;
  logic [PW-1:0]  image_RAM_rdata = '0;
  logic [PW-1:0]  image_RAM_wdata;
  logic           image_RAM_CE, image_RAM_WE, busy, done;
  logic [2:0]     dbg_state;

  assign start = cdf_generated && (command == CMD_HISTOGRAM_EQUALIZATION);

  histogram_equalizer #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_WIDTH(PW),
    .IMAGE_RAM_ADDRESS_WIDTH(IAW), .HISTOGRAM_RAM_ADDRESS_WIDTH(HAW),
    .HISTOGRAM_RAM_DATA_WIDTH(HD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .CDF_min(cdf_min_in),
    .histogram_RAM_address(histogram_RAM_address),
    .histogram_RAM_rdata(histogram_RAM_rdata),
    .histogram_RAM_CE(histogram_RAM_CE),
    .image_RAM_address(image_RAM_address), .image_RAM_rdata(image_RAM_rdata),
    .image_RAM_wdata(image_RAM_wdata), .image_RAM_CE(image_RAM_CE),
    .image_RAM_WE(image_RAM_WE), .busy(busy), .done(done), .fsm_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM models ----------------
  logic [PW-1:0] img_mem [N];
  logic [PW-1:0] init_img [N];
  logic [HD-1:0] hist_mem [L];
  logic load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) img_mem[i] <= init_img[i];
    end else if (image_RAM_CE) begin
      if (image_RAM_WE) img_mem[image_RAM_address] <= image_RAM_wdata;
      else image_RAM_rdata <= img_mem[image_RAM_address];
    end
  end

  always @(posedge clk) begin
    if (histogram_RAM_CE) histogram_RAM_rdata <= hist_mem[histogram_RAM_address];
  end

  // ---------------- protocol monitor ----------------
  bit mon_en = 1'b0;
  bit seen_img;
  int img_ce_cycles, first_img_cyc, done_cnt, done_cyc, viol_cnt;

  always @(negedge clk) begin
    if (mon_en) begin
      if (histogram_RAM_CE && (seen_img || image_RAM_CE)) viol_cnt++;
      if (image_RAM_WE && !seen_img) viol_cnt++;
      if (image_RAM_CE) begin
        if (!seen_img) first_img_cyc = cyc;
        seen_img = 1'b1;
        img_ce_cycles++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [PW-1:0] exp_q[$];
  int map_model [L];
  int lut_cyc;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Builds the CDF from init_img, fills histogram RAM, derives the mapping and
  // the LUT-phase cycle count (2 per level, plus NUM_W when a divide runs).
  task automatic prepare(input int cmin);
    int hc [L];
    int cdf, d, q;
    for (int k = 0; k < L; k++) hc[k] = 0;
    for (int i = 0; i < N; i++) hc[init_img[i]]++;
    cdf = 0;
    d = N - cmin;
    lut_cyc = 0;
    for (int k = 0; k < L; k++) begin
      cdf += hc[k];
      hist_mem[k] = HD'(cdf);
      if (d == 0) begin
        map_model[k] = k;
        lut_cyc += 2;
      end else if (cdf < cmin) begin
        map_model[k] = 0;
        lut_cyc += 2;
      end else begin
        q = ((cdf - cmin) * (L - 1) + d / 2) / d;
        map_model[k] = (q > L - 1) ? L - 1 : q;
        lut_cyc += 2 + NUM_W;
      end
    end
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  function automatic int smallest_cdf();
    for (int k = 0; k < L; k++) if (hist_mem[k] != 0) return int'(hist_mem[k]);
    return 0;
  endfunction

  task automatic run_eq(input int cmin, input bit extra_starts);
    int s;
    @(posedge clk);
    #2;
    seen_img = 1'b0; img_ce_cycles = 0; first_img_cyc = 0;
    done_cnt = 0; done_cyc = 0; viol_cnt = 0; mon_en = 1'b1;
    @(negedge clk);
    cdf_min_in = HD'(cmin); command = CMD_HISTOGRAM_EQUALIZATION; cdf_generated = 1'b1;
    s = cyc;
    @(negedge clk);
    cdf_generated = 1'b0;
    for (int i = 0; i < 20000 && done_cnt == 0; i++) begin
      cdf_min_in = HD'($urandom_range(0, 127));
      cdf_generated = extra_starts && (i == 3 || (seen_img && cyc - first_img_cyc == 40));
      @(negedge clk);
    end
    cdf_generated = 1'b0;
    if (done_cnt == 0) begin
      check("done_timeout", 0, 1);
      return;
    end
    repeat (6) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("busy_after", int'(busy), 0);
    check("latency", done_cyc - s, 1 + lut_cyc + 2 * N);
    check("pix_phase", done_cyc - first_img_cyc, 2 * N);
    check("img_ce_cycles", img_ce_cycles, 2 * N);
    check("phase_overlap", viol_cnt, 0);
    mon_en = 1'b0;
  endtask

  task automatic check_image();
    logic [PW-1:0] e;
    for (int i = 0; i < N; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("pixel", int'(img_mem[i]), int'(e));
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int nlev;
    int val [3];
    int cnt [3];
    int cmin;
    int emap [3];
  } vec_t;

  vec_t tbl [3];

  task automatic load_vector(input int t);
    int idx, j;
    logic [PW-1:0] tmp;
    idx = 0;
    for (int lv = 0; lv < tbl[t].nlev; lv++)
      for (int c = 0; c < tbl[t].cnt[lv]; c++) begin
        init_img[idx] = PW'(tbl[t].val[lv]);
        idx++;
      end
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = init_img[i]; init_img[i] = init_img[j]; init_img[j] = tmp;
    end
    exp_q.delete();
    for (int i = 0; i < N; i++)
      for (int lv = 0; lv < tbl[t].nlev; lv++)
        if (int'(init_img[i]) == tbl[t].val[lv]) exp_q.push_back(PW'(tbl[t].emap[lv]));
    prepare(tbl[t].cmin);
  endtask

  int wait_cnt;
  logic [PW-1:0] pal [4];
  int nlev, cmin_r;

  initial begin
    tbl[0] = '{2, '{10, 200, 0}, '{32, 32, 0}, 32, '{0, 255, 0}};
    tbl[1] = '{3, '{50, 100, 150}, '{16, 16, 32}, 16, '{0, 85, 255}};
    tbl[2] = '{1, '{77, 0, 0}, '{64, 0, 0}, 64, '{77, 0, 0}};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({busy, done, histogram_RAM_CE, image_RAM_CE, image_RAM_WE}), 0);
    check("reset_addr", int'({histogram_RAM_address, image_RAM_address, image_RAM_wdata}), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 3; t++) begin
      load_vector(t);
      run_eq(tbl[t].cmin, 1'b0);
      check_image();
    end

    // Extra start requests mid-LUT and mid-remap must be ignored.
    load_vector(1);
    run_eq(tbl[1].cmin, 1'b1);
    check_image();

    // Reset during the remap phase at pixel 20, then a clean rerun.
    load_vector(0);
    @(negedge clk);
    cdf_min_in = HD'(tbl[0].cmin); command = CMD_HISTOGRAM_EQUALIZATION; cdf_generated = 1'b1;
    @(negedge clk);
    cdf_generated = 1'b0;
    wait_cnt = 0;
    while (!(dbg_state == ST_PIX_READ && image_RAM_address == IAW'(20)) && wait_cnt < 20000) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("reach_pix20", int'(wait_cnt < 20000), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", int'({busy, done, histogram_RAM_CE, image_RAM_CE, image_RAM_WE}), 0);
    check("midrst_addr", int'({histogram_RAM_address, image_RAM_address, image_RAM_wdata}), 0);
    rst = 1'b0;
    wait_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (histogram_RAM_CE || image_RAM_CE || busy) wait_cnt++;
    end
    check("idle_after_rst", wait_cnt, 0);
    load_vector(0);
    run_eq(tbl[0].cmin, 1'b0);
    check_image();

    // Randomized images against the arithmetic model.
    for (int r = 0; r < 5; r++) begin
      nlev = $urandom_range(1, 4);
      for (int p = 0; p < 4; p++) pal[p] = PW'($urandom_range(0, 255));
      for (int i = 0; i < N; i++) init_img[i] = pal[$urandom_range(0, nlev - 1)];
      prepare(0);
      cmin_r = smallest_cdf();
      prepare(cmin_r);
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_q.push_back(PW'(map_model[init_img[i]]));
      run_eq(cmin_r, r[0]);
      check_image();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/histogram_equalizer.md
Name: histogram_equalizer

Overview:
Downstream consumer of the decoder's histogram path. It runs once the decoder reports CDF_generated for the HISTOGRAM_EQUALIZATION command. It reads the 256-entry CDF from histogram RAM and builds an internal level-mapping LUT using a sequential divider. It then rewrites every pixel in image RAM in place with its equalized value and pulses done.

Parameters:
IMAGE_WIDTH, 320, image width in pixels
IMAGE_HEIGHT, 240, image height in pixels
PIXEL_WIDTH, 8, bits per pixel; levels L = 2^PIXEL_WIDTH
IMAGE_RAM_ADDRESS_WIDTH, clog2(IMAGE_WIDTH*IMAGE_HEIGHT), image RAM address width
HISTOGRAM_RAM_ADDRESS_WIDTH, PIXEL_WIDTH, histogram RAM address width
HISTOGRAM_RAM_DATA_WIDTH, clog2(IMAGE_WIDTH*IMAGE_HEIGHT), CDF word width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE (tie to CDF_generated && command==HISTOGRAM_EQUALIZATION)
CDF_min  in  HISTOGRAM_RAM_DATA_WIDTH  smallest non-zero CDF value; sampled at start
histogram_RAM_address  out  HISTOGRAM_RAM_ADDRESS_WIDTH  CDF read address
histogram_RAM_rdata  in  HISTOGRAM_RAM_DATA_WIDTH  CDF read data, valid 1 cycle after CE
histogram_RAM_CE  out  1  histogram RAM read enable; this block never writes it
image_RAM_address  out  IMAGE_RAM_ADDRESS_WIDTH  pixel address
image_RAM_rdata  in  PIXEL_WIDTH  pixel read data, valid 1 cycle after CE with WE=0
image_RAM_wdata  out  PIXEL_WIDTH  equalized pixel write data
image_RAM_CE  out  1  image RAM chip enable
image_RAM_WE  out  1  image RAM write enable (1=write)
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters cleared. Reset mid-operation aborts immediately with no further RAM accesses. LUT contents are don't-care because the LUT is rebuilt on every start.
- Constants: N = IMAGE_WIDTH*IMAGE_HEIGHT; NUM_W = HISTOGRAM_RAM_DATA_WIDTH + PIXEL_WIDTH.
- States: IDLE, LUT_READ, LUT_LATCH, LUT_DIV, PIX_READ, PIX_WRITE, DONE.
- IDLE: on start=1, latch CDF_min, set k=0, go to LUT_READ. start is ignored in every other state.
- LUT_READ: histogram_RAM_CE=1, address=k. Go to LUT_LATCH.
- LUT_LATCH: capture c = rdata; D = N - CDF_min.
  - If D==0, map[k]=k and skip to the next level.
  - Else if c < CDF_min, map[k]=0 and skip to the next level.
  - Else launch the divider with numerator (c - CDF_min)*(L-1) + D/2 (floor), divisor D, then go to LUT_DIV.
- LUT_DIV: wait for the divider's done; map[k] = min(quotient, L-1).
- Level advance, taken after a skip or after LUT_DIV: if k==L-1 go to PIX_READ with a=0, else k++ and go to LUT_READ.
- PIX_READ: image_RAM_CE=1, WE=0, address=a.
- PIX_WRITE: CE=1, WE=1, address=a, wdata=map[rdata].
  - If a==N-1 go to DONE, else a++ and go to PIX_READ.
  - Cost is exactly 2 cycles per pixel; address wrap at N-1 is never reached.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- CE and WE are 0 whenever the FSM is not in a RAM-access state.
- Arithmetic is unsigned throughout; the numerator is NUM_W bits wide; there is no overflow because c ≤ N.

Decomposition:
- Shared package holds the FSM state enum, NUM_W, the RAM read latency constant (1), and the equalization command code 16'hA050.
- One sub-module, seq_divider: unsigned restoring divider, one quotient bit per cycle. Ports: clk, rst, start, numerator[NUM_W], divisor[HISTOGRAM_RAM_DATA_WIDTH], quotient[NUM_W], done. Latency is exactly NUM_W cycles from start to the done pulse.

Test Plan:
- Bench configuration: IMAGE_WIDTH=8, IMAGE_HEIGHT=8 (N=64), with behavioural 1-cycle RAM models.
- Two-level image (32 px=10, 32 px=200; CDF(0..9)=0, CDF(10..199)=32, CDF(200..)=64), CDF_min=32, start -> pixels of 10 become 0, pixels of 200 become 255, single done pulse, busy low afterwards.
- Three levels (16 px=50, 16 px=100, 32 px=150), CDF_min=16 -> 50→0, 100→85, 150→255.
- Constant image (64 px=77), CDF_min=64 (D=0) -> every pixel written back as 77, no divider launch.
- start pulsed again mid-LUT and mid-remap -> ignored; final image identical to the single-start case; exactly one done.
- rst asserted during PIX_READ at a=20 -> next cycle all outputs 0 and no RAM accesses; a new start then completes a correct full equalization.
- Count cycles from start to done -> PIX phase contributes exactly 2*64 cycles; histogram_RAM_CE never high during the PIX phase and image_RAM_WE never high during the LUT phase.
